// File: rtl/bldcm_comm_seq.sv
// Six-step BLDC commutation sequencer: DEAD/DRIVE timing, gate patterns,
// and a per-step ramp of the PWM compare value.
module bldcm_comm_seq #(
  parameter int pCounterWidth = 32,
  parameter int pStepWidth    = 32,
  parameter int pDeadWidth    = 8
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iEnable,
  input  logic                     iDir,
  input  logic [pStepWidth-1:0]    iStepPeriod,
  input  logic [pDeadWidth-1:0]    iDeadTime,
  input  logic [pCounterWidth-1:0] iDutyTarget,
  input  logic [pCounterWidth-1:0] iRampStep,
  input  logic                     iHighPwm,
  output logic [pCounterWidth-1:0] oCmpCnt,
  output logic [2:0]               oPhaseH,
  output logic [2:0]               oPhaseL,
  output logic [2:0]               oStep,
  output logic                     oRunning,
  output logic                     oStepPulse
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Phase driven high for each step: A A B B C C.
  function automatic logic [2:0] high_sel(input logic [2:0] step);
    case (step)
      3'd0, 3'd1: high_sel = 3'b001;
      3'd2, 3'd3: high_sel = 3'b010;
      3'd4, 3'd5: high_sel = 3'b100;
      default:    high_sel = 3'b000;
    endcase
  endfunction

  // Phase held low for each step: B C C A A B.
  function automatic logic [2:0] low_sel(input logic [2:0] step);
    case (step)
      3'd0, 3'd5: low_sel = 3'b010;
      3'd1, 3'd2: low_sel = 3'b100;
      3'd3, 3'd4: low_sel = 3'b001;
      default:    low_sel = 3'b000;
    endcase
  endfunction

  state_e                   state_q, state_d;
  logic [2:0]               step_q, step_d;
  logic                     dir_q, dir_d;
  logic [pDeadWidth-1:0]    dead_cnt_q, dead_cnt_d;
  logic [pStepWidth-1:0]    drive_cnt_q, drive_cnt_d;
  logic [pCounterWidth-1:0] cmp_q, cmp_d;
  logic [2:0]               phase_h_q, phase_h_d;
  logic [2:0]               phase_l_q, phase_l_d;
  logic                     running_q, running_d;
  logic                     pulse_q, pulse_d;

  logic [pDeadWidth-1:0]    dead_load;
  logic [pStepWidth-1:0]    drive_load;
  logic [pCounterWidth:0]   ramp_sum;
  logic [pCounterWidth-1:0] ramp_val;
  logic [2:0]               step_adv;

  // Timers count down to zero, so a zero setting behaves as one clock.
  assign dead_load  = (iDeadTime == '0) ? '0 : iDeadTime - pDeadWidth'(1);
  assign drive_load = (iStepPeriod == '0) ? '0 : iStepPeriod - pStepWidth'(1);

  // The extra sum bit keeps a large ramp step from wrapping past the target.
  assign ramp_sum = {1'b0, cmp_q} + {1'b0, iRampStep};
  assign ramp_val = (cmp_q < iDutyTarget)
                    ? ((ramp_sum > {1'b0, iDutyTarget}) ? iDutyTarget
                                                         : ramp_sum[pCounterWidth-1:0])
                    : iDutyTarget;

  assign step_adv = dir_q ? ((step_q == 3'd0) ? 3'd5 : step_q - 3'd1)
                          : ((step_q == 3'd5) ? 3'd0 : step_q + 3'd1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    step_d      = step_q;
    dir_d       = dir_q;
    dead_cnt_d  = dead_cnt_q;
    drive_cnt_d = drive_cnt_q;
    cmp_d       = cmp_q;
    pulse_d     = 1'b0;
    phase_h_d   = 3'b000;
    phase_l_d   = 3'b000;

    unique case (state_q)
      ST_IDLE: begin
        cmp_d = '0;
        if (iEnable) begin
          state_d    = ST_DEAD;
          dead_cnt_d = dead_load;
        end
      end
      ST_DEAD: begin
        if (!iEnable) begin
          state_d    = ST_IDLE;
          cmp_d      = '0;
          dead_cnt_d = '0;
        end else if (dead_cnt_q == '0) begin
          state_d     = ST_DRIVE;
          drive_cnt_d = drive_load;
          dir_d       = iDir;
          cmp_d       = ramp_val;
          pulse_d     = 1'b1;
        end else begin
          dead_cnt_d = dead_cnt_q - pDeadWidth'(1);
        end
      end
      ST_DRIVE: begin
        if (!iEnable) begin
          state_d     = ST_IDLE;
          cmp_d       = '0;
          drive_cnt_d = '0;
        end else if (drive_cnt_q == '0) begin
          state_d    = ST_DEAD;
          dead_cnt_d = dead_load;
          step_d     = step_adv;
        end else begin
          drive_cnt_d = drive_cnt_q - pStepWidth'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cmp_d   = '0;
      end
    endcase

    // Gates are decoded from the next state, so disable or DEAD entry clears them at the edge.
    if (state_d == ST_DRIVE) begin
      phase_h_d = high_sel(step_d) & {3{iHighPwm}};
      phase_l_d = low_sel(step_d);
    end
    running_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      step_q      <= 3'd0;
      dir_q       <= 1'b0;
      dead_cnt_q  <= '0;
      drive_cnt_q <= '0;
      cmp_q       <= '0;
      phase_h_q   <= 3'b000;
      phase_l_q   <= 3'b000;
      running_q   <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q     <= state_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      dead_cnt_q  <= dead_cnt_d;
      drive_cnt_q <= drive_cnt_d;
      cmp_q       <= cmp_d;
      phase_h_q   <= phase_h_d;
      phase_l_q   <= phase_l_d;
      running_q   <= running_d;
      pulse_q     <= pulse_d;
    end
  end

  assign oCmpCnt    = cmp_q;
  assign oPhaseH    = phase_h_q;
  assign oPhaseL    = phase_l_q;
  assign oStep      = step_q;
  assign oRunning   = running_q;
  assign oStepPulse = pulse_q;

endmodule

// File: tb/tb_bldcm_comm_seq.sv
// Self-checking bench for bldcm_comm_seq: table-driven runs with a step-entry
// scoreboard, a per-cycle gate/timing monitor, and hand-written corner sequences.
module tb_bldcm_comm_seq;

  localparam int CW = 32;
  localparam int SW = 32;
  localparam int DW = 8;

  logic          iClock      = 1'b0;
  logic          iReset      = 1'b1;
  logic          iEnable     = 1'b0;
  logic          iDir        = 1'b0;
  logic [SW-1:0] iStepPeriod = '0;
  logic [DW-1:0] iDeadTime   = '0;
  logic [CW-1:0] iDutyTarget = '0;
  logic [CW-1:0] iRampStep   = '0;
  logic          iHighPwm    = 1'b0;
  logic [CW-1:0] oCmpCnt;
  logic [2:0]    oPhaseH;
  logic [2:0]    oPhaseL;
  logic [2:0]    oStep;
  logic          oRunning;
  logic          oStepPulse;

  bldcm_comm_seq #(
    .pCounterWidth(CW),
    .pStepWidth   (SW),
    .pDeadWidth   (DW)
  ) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iEnable    (iEnable),
    .iDir       (iDir),
    .iStepPeriod(iStepPeriod),
    .iDeadTime  (iDeadTime),
    .iDutyTarget(iDutyTarget),
    .iRampStep  (iRampStep),
    .iHighPwm   (iHighPwm),
    .oCmpCnt    (oCmpCnt),
    .oPhaseH    (oPhaseH),
    .oPhaseL    (oPhaseL),
    .oStep      (oStep),
    .oRunning   (oRunning),
    .oStepPulse (oStepPulse)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic [2:0]    step;
    logic [CW-1:0] cmp;
  } exp_t;

  typedef struct {
    bit            rst;
    bit            dir;
    int            dead;
    int            period;
    logic [CW-1:0] tgt;
    logic [CW-1:0] ramp;
    int            n;
    logic [2:0]    exp_step;
    logic [CW-1:0] exp_cmp;
  } vec_t;

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         dead_len   = 0;
  int         drive_len  = 0;
  int         exp_dead   = 1;
  int         exp_period = 1;
  bit         dur_en     = 1'b0;
  logic       hp_last    = 1'b0;
  logic [2:0] cur_step   = 3'd0;
  exp_t       sb[$];
  exp_t       mon_e;
  vec_t       vecs[6];
  logic [2:0] hi_tbl[6];
  logic [2:0] lo_tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] ramp_next(input logic [CW-1:0] cur, input logic [CW-1:0] tgt,
                                              input logic [CW-1:0] stp);
    longint unsigned s;
    s = 64'(cur) + 64'(stp);
    if (cur >= tgt) return tgt;
    return (s > 64'(tgt)) ? tgt : CW'(s);
  endfunction

  function automatic logic [2:0] step_next(input logic [2:0] s, input bit dir);
    int v;
    v = (int'(s) + (dir ? 5 : 1)) % 6;
    return 3'(v);
  endfunction

  // iHighPwm is random and changes away from the rising edge.
  initial forever begin
    @(negedge iClock);
    #2;
    iHighPwm = 1'($urandom_range(0, 1));
  end

  always @(posedge iClock) hp_last <= iHighPwm;

  // Per-cycle monitor: scoreboard pops on step strobes, gate patterns, DEAD/DRIVE lengths.
  always @(negedge iClock) begin
    check("no_shoot_through", 64'(oPhaseH & oPhaseL), 64'(0));
    if (iReset) begin
      dead_len  = 0;
      drive_len = 0;
    end else begin
      check("step_pulse_first_drive", 64'(oStepPulse), 64'((oPhaseL != 3'b000) && (drive_len == 0)));
      if (oStepPulse) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_pulse: got pulse at step %0d expected none", oStep);
        end else begin
          mon_e = sb.pop_front();
          check("sb_step", 64'(oStep), 64'(mon_e.step));
          check("sb_cmp", 64'(oCmpCnt), 64'(mon_e.cmp));
        end
      end
      if (oPhaseL != 3'b000) begin
        if (dur_en && drive_len == 0) check("dead_len", 64'(dead_len), 64'(exp_dead));
        dead_len = 0;
        drive_len++;
        if (oStep < 3'd6) begin
          check("gate_low", 64'(oPhaseL), 64'(lo_tbl[oStep]));
          check("gate_high", 64'(oPhaseH), 64'(hi_tbl[oStep] & {3{hp_last}}));
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL step_range: got %0d expected 0..5", oStep);
        end
      end else if (oRunning) begin
        check("dead_gates_off", 64'(oPhaseH), 64'(0));
        if (dur_en && drive_len > 0) check("drive_len", 64'(drive_len), 64'(exp_period));
        drive_len = 0;
        dead_len++;
      end else begin
        check("idle_cmp", 64'(oCmpCnt), 64'(0));
        check("idle_gates", 64'(oPhaseH | oPhaseL), 64'(0));
        dead_len  = 0;
        drive_len = 0;
      end
    end
  end

  task automatic reset_dut();
    iEnable = 1'b0;
    @(negedge iClock);
    #1;
    iReset = 1'b1;
    #2;
    iReset = 1'b0;
    cur_step = 3'd0;
  endtask

  task automatic set_cfg(input bit dir, input int dead, input int period,
                         input logic [CW-1:0] tgt, input logic [CW-1:0] ramp);
    iDir        = dir;
    iDeadTime   = DW'(dead);
    iStepPeriod = SW'(period);
    iDutyTarget = tgt;
    iRampStep   = ramp;
    exp_dead    = (dead < 1) ? 1 : dead;
    exp_period  = (period < 1) ? 1 : period;
  endtask

  task automatic wait_size(input int n, input int budget);
    for (int c = 0; c < budget && sb.size() > n; c++) begin
      @(negedge iClock);
      #1;
    end
    check("sb_wait", 64'(sb.size()), 64'(n));
    if (sb.size() > n) sb.delete();
  endtask

  task automatic drop_and_check(input logic [2:0] exp_step);
    iEnable = 1'b0;
    @(negedge iClock);
    #1;
    check("disable_running", 64'(oRunning), 64'(0));
    check("disable_cmp", 64'(oCmpCnt), 64'(0));
    check("disable_gates", 64'({oPhaseH, oPhaseL}), 64'(0));
    check("disable_step_kept", 64'(oStep), 64'(exp_step));
  endtask

  task automatic run_vec(input vec_t v);
    logic [CW-1:0] cmp;
    logic [2:0]    s;
    logic [2:0]    last;
    if (v.rst) reset_dut();
    set_cfg(v.dir, v.dead, v.period, v.tgt, v.ramp);
    dur_en = 1'b1;
    cmp  = '0;
    s    = cur_step;
    last = cur_step;
    for (int k = 0; k < v.n; k++) begin
      cmp = ramp_next(cmp, v.tgt, v.ramp);
      sb.push_back('{step: s, cmp: cmp});
      last = s;
      s = step_next(s, v.dir);
    end
    iEnable = 1'b1;
    wait_size(0, v.n * (exp_dead + exp_period) + 8);
    check("vec_final_step", 64'(oStep), 64'(v.exp_step));
    check("vec_final_cmp", 64'(oCmpCnt), 64'(v.exp_cmp));
    drop_and_check(last);
    cur_step = last;
  endtask

  initial begin
    int len;
    hi_tbl = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    lo_tbl = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
    //          rst   dir   dead per tgt            ramp           n  step  cmp
    vecs[0] = '{1'b1, 1'b0, 2, 4, 32'd10,         32'd4,         7, 3'd0, 32'd10};
    vecs[1] = '{1'b1, 1'b1, 3, 2, 32'd100,        32'd30,        8, 3'd5, 32'd100};
    vecs[2] = '{1'b0, 1'b0, 0, 0, 32'd7,          32'd5,         4, 3'd2, 32'd7};
    vecs[3] = '{1'b1, 1'b0, 1, 1, 32'hFFFF_FFF0,  32'hF000_0000, 3, 3'd2, 32'hFFFF_FFF0};
    vecs[4] = '{1'b0, 1'b1, 5, 3, 32'd0,          32'd9,         3, 3'd0, 32'd0};
    vecs[5] = '{1'b0, 1'b1, 1, 1, 32'd50,         32'd50,        2, 3'd5, 32'd50};

    // Reset state, observed while reset is still asserted.
    #1;
    check("rst_running", 64'(oRunning), 64'(0));
    check("rst_step", 64'(oStep), 64'(0));
    check("rst_cmp", 64'(oCmpCnt), 64'(0));
    check("rst_gates", 64'({oPhaseH, oPhaseL}), 64'(0));
    check("rst_pulse", 64'(oStepPulse), 64'(0));
    @(negedge iClock);
    #1;
    iReset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Ramp 4, 8, 10, 10, then an immediate drop to a lowered target.
    reset_dut();
    set_cfg(1'b0, 2, 4, 32'd10, 32'd4);
    dur_en = 1'b1;
    sb.push_back('{step: 3'd0, cmp: 32'd4});
    sb.push_back('{step: 3'd1, cmp: 32'd8});
    sb.push_back('{step: 3'd2, cmp: 32'd10});
    sb.push_back('{step: 3'd3, cmp: 32'd10});
    sb.push_back('{step: 3'd4, cmp: 32'd3});
    iEnable = 1'b1;
    wait_size(1, 40);
    iDutyTarget = 32'd3;
    wait_size(0, 20);
    drop_and_check(3'd4);

    // Direction and period changed mid-DRIVE only take effect at the next entry.
    reset_dut();
    set_cfg(1'b0, 2, 4, 32'd10, 32'd4);
    dur_en = 1'b0;
    sb.push_back('{step: 3'd0, cmp: 32'd4});
    sb.push_back('{step: 3'd1, cmp: 32'd8});
    sb.push_back('{step: 3'd0, cmp: 32'd10});
    iEnable = 1'b1;
    wait_size(2, 20);
    iDir        = 1'b1;
    iStepPeriod = 32'd1;
    len = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge iClock);
      #1;
      if (oPhaseL == 3'b000) break;
      len++;
    end
    check("mid_state_period", 64'(len), 64'(4));
    wait_size(0, 20);
    drop_and_check(3'd0);

    // Zero configuration: strobe every second clock.
    reset_dut();
    set_cfg(1'b0, 0, 0, 32'd1, 32'd1);
    dur_en = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back('{step: 3'(k), cmp: 32'd1});
    iEnable = 1'b1;
    wait_size(3, 10);
    for (int i = 1; i <= 6; i++) begin
      @(negedge iClock);
      #1;
      check("zero_cfg_pulse", 64'(oStepPulse), 64'((i % 2) == 0));
    end
    wait_size(0, 4);
    drop_and_check(3'd3);

    // Disable during DRIVE of step 3, then resume there with the ramp restarted.
    reset_dut();
    set_cfg(1'b0, 2, 6, 32'd20, 32'd5);
    dur_en = 1'b1;
    sb.push_back('{step: 3'd0, cmp: 32'd5});
    sb.push_back('{step: 3'd1, cmp: 32'd10});
    sb.push_back('{step: 3'd2, cmp: 32'd15});
    sb.push_back('{step: 3'd3, cmp: 32'd20});
    iEnable = 1'b1;
    wait_size(0, 50);
    repeat (2) begin
      @(negedge iClock);
      #1;
    end
    drop_and_check(3'd3);
    sb.push_back('{step: 3'd3, cmp: 32'd5});
    iEnable = 1'b1;
    wait_size(0, 20);
    drop_and_check(3'd3);

    // Asynchronous reset between edges during DRIVE of step 1.
    reset_dut();
    set_cfg(1'b0, 1, 5, 32'd10, 32'd10);
    dur_en = 1'b1;
    sb.push_back('{step: 3'd0, cmp: 32'd10});
    sb.push_back('{step: 3'd1, cmp: 32'd10});
    iEnable = 1'b1;
    wait_size(0, 30);
    #1;
    iReset = 1'b1;
    #1;
    check("async_rst_running", 64'(oRunning), 64'(0));
    check("async_rst_step", 64'(oStep), 64'(0));
    check("async_rst_cmp", 64'(oCmpCnt), 64'(0));
    check("async_rst_gates", 64'({oPhaseH, oPhaseL}), 64'(0));
    check("async_rst_pulse", 64'(oStepPulse), 64'(0));
    @(posedge iClock);
    #1;
    check("async_rst_held", 64'({oRunning, oStep, oPhaseH, oPhaseL}), 64'(0));
    iEnable = 1'b0;
    @(negedge iClock);
    #1;
    iReset = 1'b0;
    @(negedge iClock);
    #1;
    check("post_rst_idle", 64'(oRunning), 64'(0));
    check("post_rst_step", 64'(oStep), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
